// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 8:1 MUX scan sequencer.
// Select order helpers keep the first/last select derivation in one place.
package mux_scan_pkg;

  localparam int CODE_W = 8;
  localparam int SEL_W  = 3;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    PRESENT = 2'd2
  } scan_state_t;

  function automatic logic [SEL_W-1:0] sel_first(input bit msb_first);
    return msb_first ? 3'd7 : 3'd0;
  endfunction

  function automatic logic [SEL_W-1:0] sel_last(input bit msb_first);
    return msb_first ? 3'd0 : 3'd7;
  endfunction

endpackage

// File: rtl/scan_sel_counter.sv
// 3-bit select register: loads the first select of the scan order, steps
// toward the last one, and flags when the last select is reached.
module scan_sel_counter
  import mux_scan_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load_first,
  input  logic             i_step,
  output logic [SEL_W-1:0] o_sel,
  output logic             o_is_last
);

  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_d;

  // The sequencer leaves the word at the last select, so no wrap is ever taken.
  always_comb begin
    sel_d = sel_q;
    if (i_load_first) begin
      sel_d = sel_first(MSB_FIRST);
    end else if (i_step) begin
      sel_d = MSB_FIRST ? (sel_q - 3'd1) : (sel_q + 3'd1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sel_q <= '0;
    end else begin
      sel_q <= sel_d;
    end
  end

  assign o_sel     = sel_q;
  assign o_is_last = (sel_q == sel_last(MSB_FIRST));

endmodule

// File: rtl/mux_8_1_scan_sequencer.sv
// Parallel-to-serial front end for an external 8:1 MUX: holds a word on the
// MUX code input, scans the select, samples the MUX after a settle time.
module mux_8_1_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter bit MSB_FIRST  = 1'b0,
  parameter int BIT_CYCLES = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load_valid,
  input  logic [CODE_W-1:0] i_load_code,
  output logic              o_load_ready,
  output logic              o_mux_en,
  output logic [CODE_W-1:0] o_mux_code,
  output logic [SEL_W-1:0]  o_mux_sel,
  input  logic              i_mux_f,
  output logic              o_bit,
  output logic              o_bit_valid,
  input  logic              i_bit_ready,
  output logic              o_done,
  input  logic              i_abort,
  output logic [1:0]        o_dbg_state
);

  // Both ports use valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; valid and data hold until that edge.

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

  scan_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              en_q, en_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              bit_q, bit_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              sel_load;
  logic              sel_step;
  logic              sel_is_last;

  scan_sel_counter #(
    .MSB_FIRST (MSB_FIRST)
  ) u_sel (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_load_first (sel_load),
    .i_step       (sel_step),
    .o_sel        (o_mux_sel),
    .o_is_last    (sel_is_last)
  );

  assign o_load_ready = (state_q == IDLE) & i_rst_n;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    en_d     = en_q;
    code_d   = code_q;
    bit_d    = bit_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    sel_load = 1'b0;
    sel_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_load_valid && o_load_ready) begin
          code_d   = i_load_code;
          sel_load = 1'b1;
          cnt_d    = '0;
          en_d     = 1'b1;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (i_abort) begin
          en_d    = 1'b0;
          valid_d = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          bit_d   = i_mux_f;
          valid_d = 1'b1;
          state_d = PRESENT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      PRESENT: begin
        // Abort takes priority over a bit handshake in the same cycle.
        if (i_abort) begin
          en_d    = 1'b0;
          valid_d = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (i_bit_ready) begin
          valid_d = 1'b0;
          if (sel_is_last) begin
            en_d    = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            sel_step = 1'b1;
            cnt_d    = '0;
            state_d  = SETTLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      code_q  <= '0;
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      code_q  <= code_d;
      bit_q   <= bit_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign o_mux_en    = en_q;
  assign o_mux_code  = code_q;
  assign o_bit       = bit_q;
  assign o_bit_valid = valid_q;
  assign o_done      = done_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_mux_8_1_scan_sequencer.sv
// Bench for the scan sequencer: two instances (LSB-first/1 settle cycle and
// MSB-first/3 settle cycles) each driving an 8:1 MUX model in the loop.
module tb_mux_8_1_scan_sequencer;

  localparam int BC0 = 1;
  localparam int BC1 = 3;

  logic       clk;
  logic       rst_n;
  logic       load_valid [2];
  logic [7:0] load_code  [2];
  logic       load_ready [2];
  logic       mux_en     [2];
  logic [7:0] mux_code   [2];
  logic [2:0] mux_sel    [2];
  logic       mux_f      [2];
  logic       bit_o      [2];
  logic       bit_valid  [2];
  logic       bit_ready  [2];
  logic       done       [2];
  logic       abort      [2];
  logic [1:0] dbg_state  [2];
  logic       rand_ready [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [0:0] exp_q0[$];
  logic [0:0] exp_q1[$];
  int done_pend  [2];
  int hs_cnt     [2];
  int start_cyc  [2];
  int stall_pend [2];
  logic stall_bit [2];
  logic [2:0] stall_sel [2];
  logic prev_valid [2];

  // ---------------- clock / reset / DUTs ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mux_8_1_scan_sequencer #(.MSB_FIRST(1'b0), .BIT_CYCLES(BC0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_load_valid(load_valid[0]), .i_load_code(load_code[0]), .o_load_ready(load_ready[0]),
    .o_mux_en(mux_en[0]), .o_mux_code(mux_code[0]), .o_mux_sel(mux_sel[0]), .i_mux_f(mux_f[0]),
    .o_bit(bit_o[0]), .o_bit_valid(bit_valid[0]), .i_bit_ready(bit_ready[0]),
    .o_done(done[0]), .i_abort(abort[0]), .o_dbg_state(dbg_state[0])
  );

  mux_8_1_scan_sequencer #(.MSB_FIRST(1'b1), .BIT_CYCLES(BC1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_load_valid(load_valid[1]), .i_load_code(load_code[1]), .o_load_ready(load_ready[1]),
    .o_mux_en(mux_en[1]), .o_mux_code(mux_code[1]), .o_mux_sel(mux_sel[1]), .i_mux_f(mux_f[1]),
    .o_bit(bit_o[1]), .o_bit_valid(bit_valid[1]), .i_bit_ready(bit_ready[1]),
    .o_done(done[1]), .i_abort(abort[1]), .o_dbg_state(dbg_state[1])
  );

  // 8:1 MUX component model: output is 0 when disabled.
  assign mux_f[0] = mux_en[0] ? mux_code[0][mux_sel[0]] : 1'b0;
  assign mux_f[1] = mux_en[1] ? mux_code[1][mux_sel[1]] : 1'b0;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int bc_of(input int d);
    return (d == 0) ? BC0 : BC1;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  // Reference model: a word is delivered as its bits in scan order.
  task automatic push_word(input int d, input logic [7:0] w);
    logic [0:0] b;
    for (int i = 0; i < 8; i++) begin
      b = (d == 1) ? w[7-i] : w[i];
      if (d == 0) exp_q0.push_back(b);
      else        exp_q1.push_back(b);
    end
  endtask

  task automatic flush(input int d);
    if (d == 0) exp_q0.delete();
    else        exp_q1.delete();
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [0:0] e;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        flush(d);
        done_pend[d]  = 0;
        stall_pend[d] = 0;
        prev_valid[d] = 1'b0;
      end else begin
        if (stall_pend[d] != 0) begin
          chk("stall_valid_held", 32'(bit_valid[d]), 32'd1);
          chk("stall_bit_held", 32'(bit_o[d]), 32'(stall_bit[d]));
          chk("stall_sel_held", 32'(mux_sel[d]), 32'(stall_sel[d]));
          stall_pend[d] = 0;
        end
        if (bit_valid[d] && !prev_valid[d])
          chk("bit_latency", 32'(cyc - start_cyc[d]), 32'(bc_of(d) + 1));
        if (bit_valid[d])
          chk("mux_en_while_valid", 32'(mux_en[d]), 32'd1);
        if (done[d]) begin
          chk("done_expected", 32'(done_pend[d] > 0), 32'd1);
          chk("done_all_bits_out", 32'(qsize(d)), 32'd0);
          if (done_pend[d] > 0) done_pend[d]--;
        end
        if (abort[d] && !load_ready[d]) begin
          flush(d);
          done_pend[d] = 0;
        end else if (bit_valid[d] && bit_ready[d]) begin
          if (qsize(d) == 0) begin
            chk("unexpected_bit", 32'd1, 32'd0);
          end else begin
            e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk("serial_bit", 32'(bit_o[d]), 32'(e));
          end
          hs_cnt[d]++;
          start_cyc[d] = cyc;
        end else if (bit_valid[d]) begin
          stall_pend[d] = 1;
          stall_bit[d]  = bit_o[d];
          stall_sel[d]  = mux_sel[d];
        end
        if (load_valid[d] && load_ready[d]) begin
          push_word(d, load_code[d]);
          done_pend[d]++;
          hs_cnt[d]    = 0;
          start_cyc[d] = cyc;
        end
        prev_valid[d] = bit_valid[d];
      end
    end
  end

  // ---------------- driver tasks ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++)
        if (rand_ready[d]) bit_ready[d] = 1'($urandom_range(0, 1));
    end
  end

  task automatic load_word(input int d, input logic [7:0] w, output int acc_cyc,
                           output logic acc_in_done);
    bit got;
    got = 1'b0;
    acc_cyc = -1;
    acc_in_done = 1'b0;
    @(posedge clk);
    #1;
    load_valid[d] = 1'b1;
    load_code[d]  = w;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      if (load_ready[d]) begin
        acc_in_done = done[d];
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        got = 1'b1;
      end
    end
    load_valid[d] = 1'b0;
    if (!got) chk("load_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_done(input int d, input int max_cyc, output int done_cyc);
    bit got;
    got = 1'b0;
    done_cyc = -1;
    for (int n = 0; n < max_cyc && !got; n++) begin
      @(negedge clk);
      if (done[d]) begin
        done_cyc = cyc;
        got = 1'b1;
      end
    end
    if (!got) chk("done_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_valid_bit(input int d, input int idx);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(posedge clk);
      #1;
      if (bit_valid[d] && hs_cnt[d] == idx) got = 1'b1;
    end
    if (!got) chk("bit_wait_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_reset_outputs(input int d);
    chk("rst_load_ready", 32'(load_ready[d]), 32'd0);
    chk("rst_mux_en", 32'(mux_en[d]), 32'd0);
    chk("rst_mux_code", 32'(mux_code[d]), 32'h00);
    chk("rst_mux_sel", 32'(mux_sel[d]), 32'd0);
    chk("rst_bit", 32'(bit_o[d]), 32'd0);
    chk("rst_bit_valid", 32'(bit_valid[d]), 32'd0);
    chk("rst_done", 32'(done[d]), 32'd0);
    chk("rst_state", 32'(dbg_state[d]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int k1, k2, dc;
    logic in_done;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      load_valid[d] = 1'b0; load_code[d] = '0; bit_ready[d] = 1'b1;
      abort[d] = 1'b0; rand_ready[d] = 1'b0;
      done_pend[d] = 0; hs_cnt[d] = 0; start_cyc[d] = 0; stall_pend[d] = 0;
      prev_valid[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs(0);
    check_reset_outputs(1);
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset0", 32'(load_ready[0]), 32'd1);
    chk("ready_after_reset1", 32'(load_ready[1]), 32'd1);

    // LSB-first word, one settle cycle
    load_word(0, 8'h1E, k1, in_done);
    wait_done(0, 60, dc);
    chk("t1_done_latency", 32'(dc - k1), 32'd16);

    // MSB-first word, three settle cycles
    load_word(1, 8'h1E, k1, in_done);
    wait_done(1, 100, dc);
    chk("t2_done_latency", 32'(dc - k1), 32'd32);

    // stall on bit 2 of 8'hA5
    load_word(0, 8'hA5, k1, in_done);
    wait_valid_bit(0, 2);
    bit_ready[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_stall_sel", 32'(mux_sel[0]), 32'd2);
      chk("t3_stall_bit", 32'(bit_o[0]), 32'd1);
      chk("t3_stall_valid", 32'(bit_valid[0]), 32'd1);
      @(posedge clk);
      #1;
    end
    bit_ready[0] = 1'b1;
    wait_done(0, 60, dc);

    // back-to-back words, second offered while the first is still running
    load_word(0, 8'hFF, k1, in_done);
    load_word(0, 8'h00, k2, in_done);
    chk("t4_accept_in_done_cycle", 32'(in_done), 32'd1);
    chk("t4_no_bubble", 32'(k2 - k1), 32'd17);
    wait_done(0, 60, dc);

    // abort coinciding with the handshake of bit 4
    load_word(0, 8'h6C, k1, in_done);
    wait_valid_bit(0, 4);
    abort[0] = 1'b1;
    @(posedge clk);
    #1;
    abort[0] = 1'b0;
    chk("t5_idle_ready", 32'(load_ready[0]), 32'd1);
    chk("t5_state_idle", 32'(dbg_state[0]), 32'd0);
    chk("t5_mux_en_off", 32'(mux_en[0]), 32'd0);
    chk("t5_valid_off", 32'(bit_valid[0]), 32'd0);
    chk("t5_sel_kept", 32'(mux_sel[0]), 32'd4);
    chk("t5_code_kept", 32'(mux_code[0]), 32'h6C);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_no_done", 32'(done[0]), 32'd0);
    end
    load_word(0, 8'h81, k1, in_done);
    wait_done(0, 60, dc);

    // abort in IDLE is ignored and does not block a load
    abort[0] = 1'b1;
    load_word(0, 8'h3A, k1, in_done);
    abort[0] = 1'b0;
    wait_done(0, 60, dc);

    // reset mid-word after bit 3
    load_word(0, 8'hC3, k1, in_done);
    wait_valid_bit(0, 4);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs(0);
    check_reset_outputs(1);
    rst_n = 1'b1;
    #1;
    chk("t6_ready_after_release", 32'(load_ready[0]), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t6_no_done", 32'(done[0]), 32'd0);
    end

    // randomized words with random downstream backpressure
    rand_ready[0] = 1'b1;
    rand_ready[1] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      for (int d = 0; d < 2; d++) begin
        load_word(d, 8'($urandom_range(0, 255)), k1, in_done);
        wait_done(d, 600, dc);
      end
    end
    rand_ready[0] = 1'b0;
    rand_ready[1] = 1'b0;
    bit_ready[0] = 1'b1;
    bit_ready[1] = 1'b1;

    repeat (4) @(negedge clk);
    chk("end_queue0_empty", 32'(exp_q0.size()), 32'd0);
    chk("end_queue1_empty", 32'(exp_q1.size()), 32'd0);
    chk("end_done_pend0", 32'(done_pend[0]), 32'd0);
    chk("end_done_pend1", 32'(done_pend[1]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
